amp_config_sender: RTL and testbench



---
 rtl/amp_cfg_pkg.sv | 30 +++
 rtl/amp_config_rom.sv | 40 ++++
 rtl/amp_config_sender.sv | 219 +++++++++++++++++++++
 tb/tb_amp_config_sender.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/amp_cfg_pkg.sv
// Shared definitions for the amplifier configuration sender: FSM encoding,
// default device address and the amplifier register map used by the init table.
package amp_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_REQ   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4,
        ST_NEXT  = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERROR = 3'd7
    } state_e;

    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h4C;

    // Wide enough to address the largest supported table (16 rows).
    localparam int ROM_IDX_W = 4;

    localparam logic [7:0] REG_PAGE_SEL     = 8'h00;
    localparam logic [7:0] REG_RESET_CTRL   = 8'h01;
    localparam logic [7:0] REG_DEVICE_CTRL1 = 8'h02;
    localparam logic [7:0] REG_PLAY_MODE    = 8'h03;
    localparam logic [7:0] REG_SAP_CTRL1    = 8'h33;
    localparam logic [7:0] REG_DIG_VOL      = 8'h4C;
    localparam logic [7:0] REG_AGAIN        = 8'h54;
    localparam logic [7:0] REG_FAULT_CLEAR  = 8'h78;

endpackage

// File: rtl/amp_config_rom.sv
// Fixed amplifier bring-up table: index -> {register address, register data}.
// Rows at or beyond NUM_REGS read back as zero.
module amp_config_rom
    import amp_cfg_pkg::*;
#(
    parameter int NUM_REGS = 8
) (
    input  logic [ROM_IDX_W-1:0] index_in,
    output logic [7:0]           reg_addr_out,
    output logic [7:0]           reg_data_out
);

    localparam logic [ROM_IDX_W:0] NUM_REGS_U = (ROM_IDX_W + 1)'(NUM_REGS);

    logic [15:0] entry_s;

    // Table lookup; row 0 selects page 0 and the last row switches to play mode.
    always_comb begin
        entry_s = 16'h0000;
        if ({1'b0, index_in} < NUM_REGS_U) begin
            case (index_in)
                4'd0:    entry_s = {REG_PAGE_SEL,     8'h00};
                4'd1:    entry_s = {REG_RESET_CTRL,   8'h11};
                4'd2:    entry_s = {REG_DEVICE_CTRL1, 8'h02};
                4'd3:    entry_s = {REG_SAP_CTRL1,    8'h00};
                4'd4:    entry_s = {REG_DIG_VOL,      8'h30};
                4'd5:    entry_s = {REG_AGAIN,        8'h00};
                4'd6:    entry_s = {REG_FAULT_CLEAR,  8'h80};
                4'd7:    entry_s = {REG_PLAY_MODE,    8'h03};
                default: entry_s = 16'h0000;
            endcase
        end else begin
            entry_s = 16'h0000;
        end
    end

    assign reg_addr_out = entry_s[15:8];
    assign reg_data_out = entry_s[7:0];

endmodule

// File: rtl/amp_config_sender.sv
// Walks the amplifier init table over a byte-level I2C master handshake,
// retrying failed writes and reporting done/error to amplifier state control.
module amp_config_sender
    import amp_cfg_pkg::*;
#(
    parameter int         NUM_REGS       = 8,
    parameter logic [6:0] DEV_ADDR       = DEFAULT_DEV_ADDR,
    parameter int         MAX_RETRIES    = 3,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter int         GAP_CYCLES     = 16
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       send_config_in,
    input  logic       i2c_busy_in,
    input  logic       i2c_done_in,
    input  logic       i2c_nack_in,
    output logic       i2c_start_out,
    output logic [6:0] i2c_dev_addr_out,
    output logic [7:0] i2c_reg_addr_out,
    output logic [7:0] i2c_data_out,
    output logic       config_busy_out,
    output logic       config_done_out,
    output logic       config_error_out
);

    localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_REGS - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYCLES - 1);

    state_e             state_q, state_d;
    logic               send_config_q, send_config_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               abort_q, abort_d;
    logic               start_q, start_d;
    logic [6:0]         dev_addr_q, dev_addr_d;
    logic [7:0]         reg_addr_q, reg_addr_d;
    logic [7:0]         data_q, data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic                 start_evt_s;
    logic                 fail_s;
    logic [ROM_IDX_W-1:0] rom_idx_s;
    logic [7:0]           rom_addr_s;
    logic [7:0]           rom_data_s;

    assign rom_idx_s     = ROM_IDX_W'(idx_q);
    assign send_config_d = send_config_in;
    assign start_evt_s   = send_config_in & ~send_config_q;

    amp_config_rom #(
        .NUM_REGS (NUM_REGS)
    ) u_rom (
        .index_in     (rom_idx_s),
        .reg_addr_out (rom_addr_s),
        .reg_data_out (rom_data_s)
    );

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        retry_d    = retry_q;
        timer_d    = timer_q;
        gap_d      = gap_q;
        abort_d    = abort_q;
        start_d    = 1'b0;
        dev_addr_d = dev_addr_q;
        reg_addr_d = reg_addr_q;
        data_d     = data_q;
        fail_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_evt_s) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                    retry_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (!send_config_in) begin
                    state_d = ST_IDLE;
                end else begin
                    dev_addr_d = DEV_ADDR;
                    reg_addr_d = rom_addr_s;
                    data_d     = rom_data_s;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!send_config_in) begin
                    state_d = ST_IDLE;
                end else if (!i2c_busy_in) begin
                    start_d = 1'b1;
                    timer_d = '0;
                    abort_d = 1'b0;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                // A request drop here is remembered; the attempt in flight still completes.
                abort_d = abort_q | ~send_config_in;
                if (i2c_done_in && !i2c_nack_in) begin
                    state_d = abort_d ? ST_IDLE : ST_NEXT;
                end else if (i2c_done_in || (timer_q == TIMER_LAST)) begin
                    fail_s = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
                if (fail_s) begin
                    retry_d = (retry_q == RETRY_MAX) ? retry_q : retry_q + 1'b1;
                    if (abort_d) begin
                        state_d = ST_IDLE;
                    end else if (retry_d == RETRY_MAX) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = '0;
                    end
                end else begin
                    gap_d = gap_q;
                end
            end
            ST_GAP: begin
                if (!send_config_in) begin
                    state_d = ST_IDLE;
                end else if (gap_q == GAP_LAST) begin
                    state_d = ST_REQ;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ST_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    retry_d = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (!send_config_in) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d  = (state_d == ST_LOAD) || (state_d == ST_REQ) || (state_d == ST_WAIT) ||
                  (state_d == ST_GAP)  || (state_d == ST_NEXT);
        done_d  = (state_d == ST_DONE);
        error_d = (state_d == ST_ERROR);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            send_config_q <= 1'b0;
            idx_q         <= '0;
            retry_q       <= '0;
            timer_q       <= '0;
            gap_q         <= '0;
            abort_q       <= 1'b0;
            start_q       <= 1'b0;
            dev_addr_q    <= 7'h00;
            reg_addr_q    <= 8'h00;
            data_q        <= 8'h00;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            send_config_q <= send_config_d;
            idx_q         <= idx_d;
            retry_q       <= retry_d;
            timer_q       <= timer_d;
            gap_q         <= gap_d;
            abort_q       <= abort_d;
            start_q       <= start_d;
            dev_addr_q    <= dev_addr_d;
            reg_addr_q    <= reg_addr_d;
            data_q        <= data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    assign i2c_start_out    = start_q;
    assign i2c_dev_addr_out = dev_addr_q;
    assign i2c_reg_addr_out = reg_addr_q;
    assign i2c_data_out     = data_q;
    assign config_busy_out  = busy_q;
    assign config_done_out  = done_q;
    assign config_error_out = error_q;

endmodule

// File: tb/tb_amp_config_sender.sv
// Directed bench for amp_config_sender: an I2C master model answers start
// pulses, and a scoreboard checks every issued write against the expected table.
module tb_amp_config_sender;

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       send_config_in = 1'b0;
    logic       i2c_busy_in = 1'b0;
    logic       i2c_done_in = 1'b0;
    logic       i2c_nack_in = 1'b0;
    logic       i2c_start_out;
    logic [6:0] i2c_dev_addr_out;
    logic [7:0] i2c_reg_addr_out;
    logic [7:0] i2c_data_out;
    logic       config_busy_out;
    logic       config_done_out;
    logic       config_error_out;

    localparam int RESP_DELAY = 10;

    int n_vec = 0;
    int n_err = 0;
    int cyc_cnt = 0;
    int pulse_cnt = 0;
    int attempt_cnt = 0;
    int nack_attempt = 0;
    int nack_cyc = -1;
    int last_done_cyc = 0;
    bit no_resp = 1'b0;
    logic prev_start = 1'b0;
    logic [15:0] mon_e;
    logic [15:0] exp_q[$];
    int start_cycs[$];

    logic [15:0] rom_tbl [0:7] = '{16'h0000, 16'h0111, 16'h0202, 16'h3300,
                                   16'h4C30, 16'h5400, 16'h7880, 16'h0303};

    amp_config_sender dut (
        .clk_in           (clk_in),
        .reset            (reset),
        .send_config_in   (send_config_in),
        .i2c_busy_in      (i2c_busy_in),
        .i2c_done_in      (i2c_done_in),
        .i2c_nack_in      (i2c_nack_in),
        .i2c_start_out    (i2c_start_out),
        .i2c_dev_addr_out (i2c_dev_addr_out),
        .i2c_reg_addr_out (i2c_reg_addr_out),
        .i2c_data_out     (i2c_data_out),
        .config_busy_out  (config_busy_out),
        .config_done_out  (config_done_out),
        .config_error_out (config_error_out)
    );

    initial forever #5 clk_in = ~clk_in;

    initial forever begin
        @(posedge clk_in);
        cyc_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic push_rows(input int first, input int last);
        for (int r = first; r <= last; r++) exp_q.push_back(rom_tbl[r]);
    endtask

    task automatic new_test();
        pulse_cnt   = 0;
        attempt_cnt = 0;
        nack_cyc    = -1;
        start_cycs.delete();
    endtask

    // Wait (bounded) for done or error; returns the cycle and the busy value one sample earlier.
    task automatic wait_status(input int budget, output int seen_cyc, output logic prev_busy);
        int t;
        t = 0;
        prev_busy = config_busy_out;
        while (config_done_out !== 1'b1 && config_error_out !== 1'b1 && t < budget) begin
            prev_busy = config_busy_out;
            cyc(1);
            t++;
        end
        seen_cyc = cyc_cnt;
    endtask

    // Scoreboard: every start pulse must match the next expected table row.
    initial forever begin
        @(negedge clk_in);
        if (i2c_start_out === 1'b1) begin
            pulse_cnt++;
            start_cycs.push_back(cyc_cnt);
            chk1("start_one_cycle", prev_start, 1'b0);
            n_vec++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_start: observed reg %0h with no expected write", i2c_reg_addr_out);
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("wr_reg_addr", 32'(i2c_reg_addr_out), 32'(mon_e[15:8]));
                chk("wr_data", 32'(i2c_data_out), 32'(mon_e[7:0]));
                chk("wr_dev_addr", 32'(i2c_dev_addr_out), 32'h4C);
            end
        end
        prev_start = i2c_start_out;
    end

    // I2C master model: answers each start after RESP_DELAY cycles unless told to stay silent.
    initial forever begin
        @(negedge clk_in);
        if (i2c_start_out === 1'b1) begin
            attempt_cnt++;
            if (!no_resp) begin
                repeat (RESP_DELAY - 1) @(negedge clk_in);
                i2c_done_in   = 1'b1;
                i2c_nack_in   = (attempt_cnt == nack_attempt);
                if (i2c_nack_in) nack_cyc = cyc_cnt;
                last_done_cyc = cyc_cnt;
                @(negedge clk_in);
                i2c_done_in = 1'b0;
                i2c_nack_in = 1'b0;
            end
        end
    end

    initial begin
        int   tdone;
        int   t;
        logic pb;

        // Reset state
        cyc(3);
        chk1("rst_start", i2c_start_out, 1'b0);
        chk1("rst_busy", config_busy_out, 1'b0);
        chk1("rst_done", config_done_out, 1'b0);
        chk1("rst_error", config_error_out, 1'b0);
        chk("rst_dev", 32'(i2c_dev_addr_out), 32'h0);
        reset = 1'b0;
        cyc(2);

        // Full sequence, all ACKed; first start exactly two cycles after the sampling edge
        new_test();
        push_rows(0, 7);
        send_config_in = 1'b1;
        cyc(1);
        chk1("lat_c1_start", i2c_start_out, 1'b0);
        cyc(1);
        chk1("lat_c2_start", i2c_start_out, 1'b0);
        chk1("lat_c2_busy", config_busy_out, 1'b1);
        cyc(1);
        chk1("lat_c3_start", i2c_start_out, 1'b1);
        wait_status(2000, tdone, pb);
        chk1("t1_done", config_done_out, 1'b1);
        chk1("t1_error", config_error_out, 1'b0);
        chk1("t1_busy_fall", config_busy_out, 1'b0);
        chk1("t1_busy_before", pb, 1'b1);
        chk1("t1_done_latency", (tdone - last_done_cyc) inside {1, 2}, 1'b1);
        chk("t1_pulses", 32'(pulse_cnt), 32'd8);
        chk("t1_queue", 32'(exp_q.size()), 32'd0);
        chk("t1_held_reg", 32'(i2c_reg_addr_out), 32'h03);
        send_config_in = 1'b0;
        cyc(1);
        chk1("t1_done_clear", config_done_out, 1'b0);
        cyc(2);

        // NACK on row 3's first attempt: retry with identical write after the gap
        new_test();
        nack_attempt = 4;
        push_rows(0, 3);
        push_rows(3, 7);
        send_config_in = 1'b1;
        wait_status(2000, tdone, pb);
        chk1("t2_done", config_done_out, 1'b1);
        chk1("t2_error", config_error_out, 1'b0);
        chk("t2_pulses", 32'(pulse_cnt), 32'd9);
        chk("t2_queue", 32'(exp_q.size()), 32'd0);
        // NACK sampled next edge, 16 GAP cycles, one REQ cycle, then the pulse is visible
        chk("t2_retry_gap", 32'(start_cycs[4] - nack_cyc), 32'd18);
        send_config_in = 1'b0;
        nack_attempt = 0;
        cyc(3);

        // No response at all: three attempts 1024+16+1 apart, then sticky error
        new_test();
        no_resp = 1'b1;
        push_rows(0, 0);
        push_rows(0, 0);
        push_rows(0, 0);
        send_config_in = 1'b1;
        wait_status(4000, tdone, pb);
        chk1("t3_error", config_error_out, 1'b1);
        chk1("t3_done", config_done_out, 1'b0);
        chk1("t3_busy", config_busy_out, 1'b0);
        chk("t3_pulses", 32'(pulse_cnt), 32'd3);
        chk("t3_space1", 32'(start_cycs[1] - start_cycs[0]), 32'd1041);
        chk("t3_space2", 32'(start_cycs[2] - start_cycs[1]), 32'd1041);
        cyc(5);
        chk1("t3_error_sticky", config_error_out, 1'b1);
        send_config_in = 1'b0;
        cyc(1);
        chk1("t3_error_clear", config_error_out, 1'b0);
        no_resp = 1'b0;
        cyc(2);

        // Master busy for 50 cycles at sequence start
        new_test();
        i2c_busy_in = 1'b1;
        push_rows(0, 7);
        send_config_in = 1'b1;
        cyc(50);
        chk("t4_no_start", 32'(pulse_cnt), 32'd0);
        chk1("t4_busy_held", config_busy_out, 1'b1);
        i2c_busy_in = 1'b0;
        cyc(1);
        chk1("t4_start_next", i2c_start_out, 1'b1);
        wait_status(2000, tdone, pb);
        chk1("t4_done", config_done_out, 1'b1);
        chk("t4_pulses", 32'(pulse_cnt), 32'd8);
        chk("t4_queue", 32'(exp_q.size()), 32'd0);
        send_config_in = 1'b0;
        cyc(3);

        // Drop the request while row 4 is in flight, then restart from row 0
        new_test();
        push_rows(0, 4);
        send_config_in = 1'b1;
        t = 0;
        while (pulse_cnt < 5 && t < 500) begin
            cyc(1);
            t++;
        end
        send_config_in = 1'b0;
        cyc(30);
        chk("t5_pulses", 32'(pulse_cnt), 32'd5);
        chk("t5_queue", 32'(exp_q.size()), 32'd0);
        chk1("t5_done", config_done_out, 1'b0);
        chk1("t5_busy", config_busy_out, 1'b0);
        chk1("t5_error", config_error_out, 1'b0);
        new_test();
        push_rows(0, 7);
        send_config_in = 1'b1;
        wait_status(2000, tdone, pb);
        chk1("t5_restart_done", config_done_out, 1'b1);
        chk("t5_restart_pulses", 32'(pulse_cnt), 32'd8);
        chk("t5_restart_queue", 32'(exp_q.size()), 32'd0);
        send_config_in = 1'b0;
        cyc(3);

        // Reset pulse while in GAP after a NACK on row 0
        new_test();
        nack_attempt = 1;
        push_rows(0, 0);
        send_config_in = 1'b1;
        t = 0;
        while (nack_cyc < 0 && t < 500) begin
            cyc(1);
            t++;
        end
        cyc(5);
        reset = 1'b1;
        send_config_in = 1'b0;
        cyc(1);
        chk1("t6_start", i2c_start_out, 1'b0);
        chk1("t6_busy", config_busy_out, 1'b0);
        chk1("t6_done", config_done_out, 1'b0);
        chk1("t6_error", config_error_out, 1'b0);
        chk("t6_dev", 32'(i2c_dev_addr_out), 32'h0);
        chk("t6_reg", 32'(i2c_reg_addr_out), 32'h0);
        chk("t6_data", 32'(i2c_data_out), 32'h0);
        reset = 1'b0;
        nack_attempt = 0;
        cyc(30);
        chk("t6_no_start", 32'(pulse_cnt), 32'd1);
        chk("t6_queue", 32'(exp_q.size()), 32'd0);
        chk1("t6_idle_busy", config_busy_out, 1'b0);
        new_test();
        push_rows(0, 7);
        send_config_in = 1'b1;
        wait_status(2000, tdone, pb);
        chk1("t6_restart_done", config_done_out, 1'b1);
        chk("t6_restart_pulses", 32'(pulse_cnt), 32'd8);
        chk("t6_restart_queue", 32'(exp_q.size()), 32'd0);
        send_config_in = 1'b0;
        cyc(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
